// File: rtl/hist_eq_lut.sv
// Histogram-equalisation LUT builder and 1-cycle pixel mapper.
// Builds an 8-bit LUT from a 256-bin histogram into a shadow bank, then swaps it in.
module hist_eq_lut #(
  parameter int CNT_W = 16,
  parameter int CDF_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       hist_rd_addr,
  input  logic [CNT_W-1:0] hist_rd_data,
  output logic             busy,
  output logic             done,
  output logic             lut_valid,
  input  logic [7:0]       pix_in,
  input  logic             pix_valid,
  output logic [7:0]       pix_out,
  output logic             pix_out_valid
);

  localparam int NW = CDF_W + 8;

  typedef enum logic [2:0] {S_IDLE, S_P1, S_RD, S_ACC, S_DIV, S_WR, S_SWAP} state_t;

  state_t          state_reg, state_next;
  logic [8:0]      cnt_reg;
  logic [7:0]      bin_reg;
  logic [2:0]      div_cnt_reg;
  logic [CDF_W-1:0] total_reg, cdf_reg, cdf_min_reg;
  logic            found_reg;
  logic [NW-1:0]   rem_reg, dvs_reg;
  logic            den_zero_reg;
  logic [7:0]      quo_reg;
  logic            active_reg, lut_valid_reg;
  logic            lut_we;

  logic [7:0]      lut_mem [0:511];
  logic [7:0]      ram_rd_reg;
  logic [7:0]      pix_d_reg;
  logic            map_sel_reg, pix_out_valid_reg;

  logic [CDF_W-1:0] data_ext, cdf_new, cdf_diff;
  logic [NW-1:0]    diff_ext, num_c, den_c;
  logic [7:0]       wr_data;

  assign data_ext = {{(CDF_W-CNT_W){1'b0}}, hist_rd_data};
  assign cdf_new  = cdf_reg + data_ext;
  assign cdf_diff = (cdf_new >= cdf_min_reg) ? (cdf_new - cdf_min_reg) : '0;
  assign diff_ext = {8'd0, cdf_diff};
  // x*255 as (x<<8)-x; the result always fits in NW bits
  assign num_c    = (diff_ext << 8) - diff_ext;
  assign den_c    = {8'd0, total_reg - cdf_min_reg};
  assign wr_data  = den_zero_reg ? bin_reg : quo_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    hist_rd_addr = 8'd0;
    busy         = (state_reg != S_IDLE);
    done         = 1'b0;
    lut_we       = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_P1;
      S_P1: begin
        hist_rd_addr = cnt_reg[7:0];
        if (cnt_reg == 9'd256) state_next = S_RD;
      end
      S_RD: begin
        hist_rd_addr = bin_reg;
        state_next   = S_ACC;
      end
      S_ACC: state_next = S_DIV;
      S_DIV: if (div_cnt_reg == 3'd7) state_next = S_WR;
      S_WR: begin
        lut_we     = 1'b1;
        state_next = (bin_reg == 8'd255) ? S_SWAP : S_RD;
      end
      S_SWAP: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      bin_reg       <= '0;
      div_cnt_reg   <= '0;
      total_reg     <= '0;
      cdf_reg       <= '0;
      cdf_min_reg   <= '0;
      found_reg     <= 1'b0;
      rem_reg       <= '0;
      dvs_reg       <= '0;
      den_zero_reg  <= 1'b0;
      quo_reg       <= '0;
      active_reg    <= 1'b0;
      lut_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          cnt_reg     <= '0;
          total_reg   <= '0;
          cdf_min_reg <= '0;
          found_reg   <= 1'b0;
        end
        S_P1: begin
          cnt_reg <= cnt_reg + 9'd1;
          // data for bin cnt-1 arrives while address cnt is driven
          if (cnt_reg != 9'd0) begin
            total_reg <= total_reg + data_ext;
            if (!found_reg && hist_rd_data != '0) begin
              cdf_min_reg <= data_ext;
              found_reg   <= 1'b1;
            end
          end
          if (cnt_reg == 9'd256) begin
            cdf_reg <= '0;
            bin_reg <= '0;
          end
        end
        S_ACC: begin
          cdf_reg      <= cdf_new;
          rem_reg      <= num_c;
          dvs_reg      <= den_c << 7;
          den_zero_reg <= (den_c == '0);
          div_cnt_reg  <= '0;
          quo_reg      <= '0;
        end
        S_DIV: begin
          if (rem_reg >= dvs_reg) begin
            rem_reg <= rem_reg - dvs_reg;
            quo_reg <= {quo_reg[6:0], 1'b1};
          end else begin
            quo_reg <= {quo_reg[6:0], 1'b0};
          end
          dvs_reg     <= dvs_reg >> 1;
          div_cnt_reg <= div_cnt_reg + 3'd1;
        end
        S_WR: bin_reg <= bin_reg + 8'd1;
        S_SWAP: begin
          active_reg    <= ~active_reg;
          lut_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Both banks share one RAM: upper address bit is the bank select
  always_ff @(posedge clk) begin
    if (lut_we) lut_mem[{~active_reg, bin_reg}] <= wr_data;
    ram_rd_reg <= lut_mem[{active_reg, pix_in}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_d_reg         <= '0;
      map_sel_reg       <= 1'b0;
      pix_out_valid_reg <= 1'b0;
    end else begin
      pix_d_reg         <= pix_in;
      map_sel_reg       <= lut_valid_reg;
      pix_out_valid_reg <= pix_valid;
    end
  end

  assign pix_out       = map_sel_reg ? ram_rd_reg : pix_d_reg;
  assign pix_out_valid = pix_out_valid_reg;
  assign lut_valid     = lut_valid_reg;

endmodule
